quad_enc_bank: RTL and testbench



---
 rtl/quad_enc_bank.sv | 196 +++++++++++++++++++
 tb/tb_quad_enc_bank.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_enc_bank.sv
// quad_enc_bank: NUM_CH quadrature encoders (A/B + button) with per-channel range, mode and sticky status.
// Define QUAD_IRQ_EN to add the CTRL[4:2] interrupt mask and a live irq output.
module quad_enc_bank #(
  parameter int NUM_CH   = 4,
  parameter int CH_AW    = 2,
  parameter int CNT_W    = 8,
  parameter int FILT_LEN = 4,
  parameter int MAX_RST  = 23
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2*NUM_CH-1:0] quad,
  input  logic [NUM_CH-1:0]   button,
  input  logic                write,
  input  logic                read,
  input  logic [CH_AW+1:0]    address,
  input  logic [31:0]         data_in,
  output logic [31:0]         data_out,
  output logic                irq
);

`ifdef QUAD_IRQ_EN
  localparam int CTRL_W = 5;
`else
  localparam int CTRL_W = 2;
`endif

  localparam logic [3:0]        FILT_LAST = 4'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0]  MAX_INIT  = CNT_W'(MAX_RST);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CTRL_W-1:0] CTRL_INIT = CTRL_W'(1);

  logic [CH_AW-1:0]         chIdx;
  logic [1:0]               regSel;
  logic [NUM_CH-1:0][31:0]  rdVal;
  logic [NUM_CH-1:0]        irqVec;
  logic [31:0]              rdMux;
  logic [31:0]              dataOut_q;
  logic                     irq_q;
  logic                     unusedData;

  assign chIdx      = address[CH_AW+1:2];
  assign regSel     = address[1:0];
  assign unusedData = ^data_in[31:CNT_W];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [2:0]            raw;
    logic [2:0]            sync1_q, sync2_q;
    logic [2:0]            filt_q, filt_d;
    logic [2:0]            prev_q;
    logic [2:0][3:0]       filtCnt_q, filtCnt_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      max_q, max_d;
    logic [3:1]            sticky_q, sticky_d;
    logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
    logic [3:0]            trans;
    logic                  selW, stepVld, stepUp, stepErr, stepApplied, press;
    logic [31:0]           rdSel;

    // Bit order {button, B, A} keeps A/B at the bottom for the Gray decode.
    assign raw   = {button[c], quad[2*c+1], quad[2*c]};
    assign selW  = write && (32'(chIdx) == 32'(c));
    assign trans = {prev_q[1:0], filt_q[1:0]};
    assign press = filt_q[2] && !prev_q[2];

    always_comb begin
      filt_d    = filt_q;
      filtCnt_d = '0;
      for (int b = 0; b < 3; b++) begin
        if (sync2_q[b] != filt_q[b]) begin
          if (filtCnt_q[b] == FILT_LAST) begin
            filt_d[b] = sync2_q[b];
          end else begin
            filtCnt_d[b] = filtCnt_q[b] + 4'd1;
          end
        end
      end
    end

    // x1 mode only honours the A-rising transitions: 00->01 forward, 10->11 reverse.
    always_comb begin
      stepVld = 1'b0;
      stepUp  = 1'b0;
      stepErr = 1'b0;
      case (trans)
        4'b0001, 4'b0111, 4'b1110, 4'b1000: begin
          stepUp  = 1'b1;
          stepVld = ctrl_q[1] || (trans == 4'b0001);
        end
        4'b0100, 4'b1101, 4'b1011, 4'b0010: begin
          stepVld = ctrl_q[1] || (trans == 4'b1011);
        end
        4'b0011, 4'b1100, 4'b0110, 4'b1001: stepErr = 1'b1;
        default: ;
      endcase
    end

    assign stepApplied = stepVld && ctrl_q[0] && !(selW && !regSel[1]);

    always_comb begin
      count_d  = count_q;
      max_d    = max_q;
      ctrl_d   = ctrl_q;
      sticky_d = sticky_q;
      if (selW && regSel == 2'd2) begin
        sticky_d = sticky_q & ~data_in[3:1];
      end
      sticky_d = sticky_d | {stepErr, stepApplied, press};
      if (selW && regSel == 2'd0) begin
        count_d = (data_in[CNT_W-1:0] > max_q) ? max_q : data_in[CNT_W-1:0];
      end else if (selW && regSel == 2'd1) begin
        max_d = data_in[CNT_W-1:0];
        if (data_in[CNT_W-1:0] < count_q) begin
          count_d = data_in[CNT_W-1:0];
        end
      end else if (stepApplied) begin
        if (stepUp) begin
          count_d = (count_q >= max_q) ? '0 : count_q + CNT_ONE;
        end else begin
          count_d = (count_q == '0) ? max_q : count_q - CNT_ONE;
        end
      end
      if (selW && regSel == 2'd3) begin
        ctrl_d = data_in[CTRL_W-1:0];
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync1_q   <= '0;
        sync2_q   <= '0;
        filt_q    <= '0;
        prev_q    <= '0;
        filtCnt_q <= '0;
        count_q   <= '0;
        max_q     <= MAX_INIT;
        sticky_q  <= '0;
        ctrl_q    <= CTRL_INIT;
      end else begin
        sync1_q   <= raw;
        sync2_q   <= sync1_q;
        filt_q    <= filt_d;
        prev_q    <= filt_q;
        filtCnt_q <= filtCnt_d;
        count_q   <= count_d;
        max_q     <= max_d;
        sticky_q  <= sticky_d;
        ctrl_q    <= ctrl_d;
      end
    end

    always_comb begin
      rdSel = '0;
      case (regSel)
        2'd0:    rdSel = 32'(count_q);
        2'd1:    rdSel = 32'(max_q);
        2'd2:    rdSel = {28'd0, sticky_q, filt_q[2]};
        default: rdSel = 32'(ctrl_q);
      endcase
    end

    assign rdVal[c] = rdSel;

`ifdef QUAD_IRQ_EN
    assign irqVec[c] = |(sticky_q & ctrl_q[4:2]);
`else
    assign irqVec[c] = 1'b0;
`endif
  end

  // Unpopulated channel slots never match, so they read 0 and swallow writes.
  always_comb begin
    rdMux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (32'(chIdx) == 32'(c)) begin
        rdMux = rdVal[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dataOut_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      if (read) begin
        dataOut_q <= rdMux;
      end
      irq_q <= |irqVec;
    end
  end

  assign data_out = dataOut_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_quad_enc_bank.sv
// tb_quad_enc_bank: directed and randomized checks of quad_enc_bank against a position-level encoder model.
module tb_quad_enc_bank;
  localparam int NUM_CH   = 4;
  localparam int CH_AW    = 2;
  localparam int CNT_W    = 8;
  localparam int FILT_LEN = 4;
  localparam int MAX_RST  = 23;
  localparam int SETTLE   = FILT_LEN + 6;
`ifdef QUAD_IRQ_EN
  localparam logic IRQ_BUILD = 1'b1;
`else
  localparam logic IRQ_BUILD = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic [2*NUM_CH-1:0] quad;
  logic [NUM_CH-1:0]   button;
  logic                write;
  logic                read;
  logic [CH_AW+1:0]    address;
  logic [31:0]         data_in;
  logic [31:0]         data_out;
  logic                irq;

  always #5 clk = ~clk;

  quad_enc_bank #(
    .NUM_CH(NUM_CH), .CH_AW(CH_AW), .CNT_W(CNT_W), .FILT_LEN(FILT_LEN), .MAX_RST(MAX_RST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .quad(quad), .button(button), .write(write), .read(read),
    .address(address), .data_in(data_in), .data_out(data_out), .irq(irq)
  );

  int         checks = 0;
  int         failures = 0;
  int         expCount [NUM_CH];
  int         expMax   [NUM_CH];
  int         phase    [NUM_CH];
  bit         expEn    [NUM_CH];
  bit         expX4    [NUM_CH];
  bit         expChg   [NUM_CH];
  logic [1:0] gray     [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic [31:0] rd;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expVal);
    checks++;
    if (obs !== expVal) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expVal);
    end
  endtask

  task automatic applyStimulus(input int ch, input logic [1:0] ab);
    quad[2*ch +: 2] = ab;
    repeat (SETTLE) @(negedge clk);
  endtask

  task automatic busWrite(input int ch, input int r, input logic [31:0] d);
    address = 4'(ch * 4 + r);
    data_in = d;
    write   = 1'b1;
    @(negedge clk);
    write   = 1'b0;
  endtask

  task automatic busRead(input int ch, input int r, output logic [31:0] d);
    address = 4'(ch * 4 + r);
    read    = 1'b1;
    @(negedge clk);
    read    = 1'b0;
    d       = data_out;
  endtask

  task automatic modelMax(input int ch, input int m);
    expMax[ch] = m;
    if (expCount[ch] > m) expCount[ch] = m;
  endtask

  task automatic modelCount(input int ch, input int v);
    expCount[ch] = (v > expMax[ch]) ? expMax[ch] : v;
  endtask

  // Position moves by one per counted Gray step, wrapping within 0..MAX.
  task automatic encStep(input int ch, input bit fwd);
    logic [1:0] oldAb, newAb;
    bit counts;
    oldAb     = gray[phase[ch]];
    phase[ch] = fwd ? (phase[ch] + 1) % 4 : (phase[ch] + 3) % 4;
    newAb     = gray[phase[ch]];
    counts    = expX4[ch] || (!oldAb[0] && newAb[0]);
    if (counts && expEn[ch]) begin
      expChg[ch]   = 1'b1;
      expCount[ch] = fwd ? (expCount[ch] + 1) % (expMax[ch] + 1)
                         : (expCount[ch] + expMax[ch]) % (expMax[ch] + 1);
    end
    applyStimulus(ch, newAb);
  endtask

  task automatic glitch(input int ch, input int bitSel, input int len);
    quad[2*ch + bitSel] = ~quad[2*ch + bitSel];
    repeat (len) @(negedge clk);
    quad[2*ch + bitSel] = ~quad[2*ch + bitSel];
    repeat (SETTLE) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; quad = '0; button = '0; write = 1'b0; read = 1'b0; address = '0; data_in = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      expCount[c] = 0; expMax[c] = MAX_RST; phase[c] = 0;
      expEn[c] = 1'b1; expX4[c] = 1'b0; expChg[c] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    checkOutput("rst_data_out", data_out, 32'h0);
    checkOutput("rst_irq", {31'd0, irq}, 32'h0);
    busRead(0, 0, rd); checkOutput("rst_count", rd, 32'd0);
    busRead(0, 1, rd); checkOutput("rst_max", rd, 32'd23);
    busRead(0, 2, rd); checkOutput("rst_status", rd, 32'h0);
    busRead(0, 3, rd); checkOutput("rst_ctrl", rd, 32'h1);

    // ch1, x1 mode: one count per full forward cycle, wrapping at 23.
    for (int cyc = 0; cyc < 25; cyc++) begin
      for (int s = 0; s < 4; s++) encStep(1, 1'b1);
      busRead(1, 0, rd); checkOutput("ch1_fwd", rd, 32'(expCount[1]));
    end
    for (int cyc = 0; cyc < 3; cyc++) begin
      for (int s = 0; s < 4; s++) encStep(1, 1'b0);
      busRead(1, 0, rd); checkOutput("ch1_rev", rd, 32'(expCount[1]));
    end
    busRead(1, 2, rd); checkOutput("ch1_chg", rd, 32'h4);

    // ch2, x4 mode with full 8-bit range, then short glitches on A.
    busWrite(2, 3, 32'h3); expX4[2] = 1'b1;
    busWrite(2, 1, 32'd255); modelMax(2, 255);
    for (int s = 0; s < 12; s++) encStep(2, 1'b1);
    busRead(2, 0, rd); checkOutput("ch2_x4", rd, 32'd12);
    glitch(2, 0, FILT_LEN - 1);
    busRead(2, 0, rd); checkOutput("ch2_glitch_long", rd, 32'd12);
    glitch(2, 0, 1);
    busRead(2, 0, rd); checkOutput("ch2_glitch_short", rd, 32'(expCount[2]));

    // Read and write in the same cycle return the pre-write value; data_out then holds.
    address = 4'(2 * 4); data_in = 32'd7; write = 1'b1; read = 1'b1;
    @(negedge clk);
    write = 1'b0; read = 1'b0;
    checkOutput("rw_prewrite", data_out, 32'd12);
    modelCount(2, 7);
    busWrite(2, 1, 32'd255);
    repeat (3) @(negedge clk);
    checkOutput("rd_hold", data_out, 32'd12);
    busRead(2, 0, rd); checkOutput("rw_postwrite", rd, 32'd7);

    // ch0: A and B flipping together is illegal.
    applyStimulus(0, 2'b11);
    busRead(0, 2, rd); checkOutput("err_set", rd, 32'h8);
    busRead(0, 0, rd); checkOutput("err_count", rd, 32'd0);
    applyStimulus(0, 2'b00);
    busWrite(0, 2, 32'h8);
    busRead(0, 2, rd); checkOutput("err_clear", rd, 32'h0);

    // ch1: MAX shrink clamps COUNT; COUNT write overrides a coincident step.
    busWrite(1, 0, 32'd20); modelCount(1, 20);
    busRead(1, 0, rd); checkOutput("cnt_wr", rd, 32'd20);
    busWrite(1, 1, 32'd10); modelMax(1, 10);
    busRead(1, 0, rd); checkOutput("max_clamp", rd, 32'd10);
    busWrite(1, 0, 32'd50); modelCount(1, 50);
    busRead(1, 0, rd); checkOutput("cnt_clamp", rd, 32'd10);
    quad[3:2] = 2'b01; phase[1] = 1;
    repeat (FILT_LEN + 2) @(negedge clk);
    busWrite(1, 0, 32'd5); modelCount(1, 5);
    repeat (SETTLE) @(negedge clk);
    busRead(1, 0, rd); checkOutput("wr_vs_step", rd, 32'd5);
    for (int s = 0; s < 4; s++) encStep(1, 1'b1);
    busRead(1, 0, rd); checkOutput("after_override", rd, 32'(expCount[1]));

    // ch3: button press capture; CTRL[2] masks PRESS onto irq.
    busWrite(3, 3, 32'h05);
    busRead(3, 3, rd); checkOutput("ch3_ctrl", rd, IRQ_BUILD ? 32'h05 : 32'h01);
    button[3] = 1'b1;
    repeat (SETTLE) @(negedge clk);
    busRead(3, 2, rd); checkOutput("press_status", rd, 32'h3);
    checkOutput("press_irq", {31'd0, irq}, {31'd0, IRQ_BUILD});
    button[3] = 1'b0;
    repeat (SETTLE) @(negedge clk);
    busRead(3, 2, rd); checkOutput("press_sticky", rd, 32'h2);
    button[3] = 1'b1;
    repeat (FILT_LEN + 2) @(negedge clk);
    busWrite(3, 2, 32'h2);
    checkOutput("w1c_race_irq", {31'd0, irq}, {31'd0, IRQ_BUILD});
    repeat (2) @(negedge clk);
    checkOutput("w1c_race_irq2", {31'd0, irq}, {31'd0, IRQ_BUILD});
    busRead(3, 2, rd); checkOutput("w1c_race_status", rd, 32'h3);
    button[3] = 1'b0;
    repeat (SETTLE) @(negedge clk);
    busWrite(3, 2, 32'h2);
    checkOutput("irq_clear_lag", {31'd0, irq}, {31'd0, IRQ_BUILD});
    @(negedge clk);
    checkOutput("irq_cleared", {31'd0, irq}, 32'h0);
    busRead(3, 2, rd); checkOutput("press_cleared", rd, 32'h0);

    // Randomized ranges, modes, enables, writes, steps and glitches on every channel.
    for (int c = 0; c < NUM_CH; c++) begin
      for (int round = 0; round < 2; round++) begin
        int mx, v;
        busWrite(c, 2, 32'hE); expChg[c] = 1'b0;
        mx = $urandom_range(0, 40);
        busWrite(c, 1, 32'(mx)); modelMax(c, mx);
        expEn[c] = ($urandom_range(0, 3) != 0);
        expX4[c] = $urandom_range(0, 1) == 1;
        busWrite(c, 3, {30'd0, expX4[c], expEn[c]});
        v = $urandom_range(0, 50);
        busWrite(c, 0, 32'(v)); modelCount(c, v);
        busRead(c, 0, rd); checkOutput("rnd_wr", rd, 32'(expCount[c]));
        for (int op = 0; op < 24; op++) begin
          if ($urandom_range(0, 4) == 0) begin
            glitch(c, $urandom_range(0, 1), $urandom_range(1, FILT_LEN - 1));
          end else begin
            encStep(c, $urandom_range(0, 1) == 1);
          end
        end
        busRead(c, 0, rd); checkOutput("rnd_count", rd, 32'(expCount[c]));
        busRead(c, 2, rd); checkOutput("rnd_status", rd, expChg[c] ? 32'h4 : 32'h0);
      end
    end
    checkOutput("final_irq", {31'd0, irq}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
